// File: rtl/mul_pkg.sv
// Shared definitions for the sequential limb multiplier: op encodings, FSM states
// and the limb-pair sequencing helper.
package mul_pkg;

  localparam int LIMB  = 16;
  localparam int MAX_N = 4;

  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MULH_SS = 2'b01,
    MULH_SU = 2'b10,
    MULH_UU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    CORR,
    DONE
  } state_e;

  // Next limb-pair index after k (i = k/n, j = k%n); n*n means no pair remains.
  // MUL skips pairs whose weight lands entirely in the discarded high half.
  function automatic int next_limb(op_e op, int k, int n);
    int nxt;
    nxt = n * n;
    for (int t = MAX_N * MAX_N - 1; t > 0; t--) begin
      if (t > k && t < n * n && (op != MUL_LO || (t / n + t % n) < n)) nxt = t;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mul_seq_if.sv
// Request/response handshake bundle between the execute stage and mul_seq.
interface mul_seq_if #(
  parameter int WIDTH = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  mul_pkg::op_e      op;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/dsp_mul16u.sv
// Unsigned 16x16->32 partial-product unit; written so it maps onto one SB_MAC16
// with every pipeline register bypassed and both operands unsigned.
module dsp_mul16u (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = 32'(a) * 32'(b);
endmodule

// File: rtl/mul_seq.sv
// Sequential WIDTH x WIDTH multiplier: one 16x16 limb product per cycle into a
// 2*WIDTH accumulator, then a single signed-correction step.
module mul_seq
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mul_seq_if.slave    bus
);

  localparam int N  = WIDTH / LIMB;
  localparam int KN = N * N;
  localparam int KW = (KN > 1) ? $clog2(KN) : 1;
  localparam int AW = 2 * WIDTH;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [KW-1:0]     k_q, k_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  int                pair_i, pair_j, nxt_k;
  logic [LIMB-1:0]   dsp_a, dsp_b;
  logic [2*LIMB-1:0] dsp_p;
  logic [AW-1:0]     pp_shifted, corr;
  logic              sa, sb;

  dsp_mul16u u_dsp (
    .a (dsp_a),
    .b (dsp_b),
    .p (dsp_p)
  );

  // The first limb pair is taken straight from the request at accept, which
  // saves a cycle and gives the N^2+1 / N(N+1)/2+1 latencies.
  always_comb begin : operand_sel
    pair_i = int'(k_q) / N;
    pair_j = int'(k_q) % N;
    if (state_q == IDLE) begin
      dsp_a = bus.a[LIMB-1:0];
      dsp_b = bus.b[LIMB-1:0];
      nxt_k = next_limb(bus.op, 0, N);
    end else begin
      dsp_a = a_q[LIMB*pair_i +: LIMB];
      dsp_b = b_q[LIMB*pair_j +: LIMB];
      nxt_k = next_limb(op_q, int'(k_q), N);
    end
    pp_shifted = AW'(dsp_p) << (LIMB * (pair_i + pair_j));
    sa   = a_q[WIDTH-1] && (op_q == MULH_SS || op_q == MULH_SU);
    sb   = b_q[WIDTH-1] && (op_q == MULH_SS);
    corr = (sa ? {b_q, {WIDTH{1'b0}}} : '0) + (sb ? {a_q, {WIDTH{1'b0}}} : '0);
  end

  always_comb begin : next_state
    // NOTE: every _d starts as its _q so no branch of the case can infer a latch.
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    acc_d       = acc_q;
    k_d         = k_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = bus.b;
          op_d       = bus.op;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          k_d        = '0;
          if (bus.a == '0 || bus.b == '0) begin
            acc_d       = '0;
            result_d    = '0;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            acc_d = AW'(dsp_p);
            if (nxt_k >= KN) begin
              state_d = CORR;
            end else begin
              state_d = MAC;
              k_d     = KW'(nxt_k);
            end
          end
        end
      end
      MAC: begin
        acc_d = acc_q + pp_shifted;
        if (nxt_k >= KN) begin
          state_d = CORR;
          k_d     = '0;
        end else begin
          k_d = KW'(nxt_k);
        end
      end
      CORR: begin
        // Subtracting the sign-weighted cross terms turns the unsigned product signed.
        acc_d       = acc_q - corr;
        result_d    = (op_q == MUL_LO) ? acc_d[WIDTH-1:0] : acc_d[AW-1:WIDTH];
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= MUL_LO;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/mul_seq.md
# mul_seq

Parametrised sequential integer multiplier for the sail-core execute stage. It builds a WIDTH×WIDTH product from one shared unsigned 16×16 SB_MAC16 partial-product unit, one limb pair per cycle, and applies signed correction at the end. It supports the four RV32M multiply flavours and uses valid/ready handshakes on both sides. It replaces the single fixed 16×16 signed combinational multiply wherever full-width or high-half products are needed.

## Interface
- WIDTH, 32: operand and result width; multiple of 16, range 16..64; N = WIDTH/16 limbs.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- op  in  2  00 MUL (low half), 01 MULH (s×s, high), 10 MULHSU (s×u, high), 11 MULHU (u×u, high).
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- result  out  WIDTH  selected product half.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, MAC, CORR, DONE.
- IDLE: in_ready=1. On accept, latch a, b, op, clear 2·WIDTH accumulator, and set index k=0.
  - If a==0 or b==0, go directly to DONE with result 0 (zero early-out).
  - Otherwise go to MAC.
- MAC: limb indices i=k/N (a), j=k%N (b).
  - Each cycle: acc += (a_i × b_j, unsigned 32-bit) << 16·(i+j), modulo 2^(2·WIDTH).
  - For op=MUL, pairs with i+j ≥ N are skipped. k advances to the next pair with i+j < N, so no idle cycles occur.
  - After the last pair, go to CORR.
- CORR, one cycle:
  - sa = a[WIDTH-1] && op∈{MULH,MULHSU}.
  - sb = b[WIDTH-1] && op==MULH.
  - acc -= (sa ? b<<WIDTH : 0) + (sb ? a<<WIDTH : 0), modulo 2^(2·WIDTH).
  - Then go to DONE.
- DONE: out_valid=1. result = op==MUL ? acc[WIDTH-1:0] : acc[2·WIDTH-1:WIDTH], held stable until the output handshake. On the handshake, go to IDLE.
- in_ready=0 in MAC, CORR and DONE. No request is accepted in the same cycle as an output handshake.
- Inputs a, b and op are sampled only at accept. Changes afterwards have no effect.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, busy=0, acc=0, state=IDLE.
- rst in any state returns to IDLE on the next edge. An in-flight operation is discarded and no out_valid is produced.
- Latency is counted from the accept edge to the first cycle with out_valid=1:
  - High-half ops: N²+1 cycles (5 for WIDTH=32).
  - MUL: N(N+1)/2+1 cycles (4 for WIDTH=32).
  - Zero early-out: 1 cycle.
- Throughput: one operation per latency+1 cycles when out_ready is held high, because the DONE→IDLE cycle always costs one cycle.
- Backpressure: DONE persists indefinitely with result stable and busy=1.
- The partial-product unit is combinational. The accumulator add is the only registered path per MAC cycle.

## Structure
- Package mul_pkg holds:
  - op encodings (MUL_LO, MULH_SS, MULH_SU, MULH_UU);
  - LIMB = 16;
  - state enum;
  - a function returning the next valid limb index for a given op and N.
- Sub-module dsp_mul16u: combinational unsigned 16×16→32 SB_MAC16 instance with all registers bypassed, A_SIGNED=B_SIGNED=0, and all unused ports tied off. It is instantiated exactly once in mul_seq.

## Test plan
- WIDTH=32, MULHU, a=b=0xFFFFFFFF → result 0xFFFFFFFE; out_valid 5 cycles after accept; busy high throughout.
- MULH, a=b=0x80000000 → 0x40000000. MULH, a=0xFFFFFFFF, b=0x00000002 → 0xFFFFFFFF.
- MULHSU, a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. MUL, a=0x12345678, b=0x9ABCDEF0 → 0x242D2080, out_valid 4 cycles after accept.
- Zero early-out: MULHU, a=0, b=0xDEADBEEF → 0, out_valid 1 cycle after accept. Then hold out_ready=0 for 3 cycles → result stable, in_ready=0; in_ready returns 1 on the cycle after the handshake.
- Assert rst during the second MAC cycle → next cycle all outputs at reset values, no out_valid. A following MULHU 3×5 completes normally with result 0.
- Randomised sweep, WIDTH ∈ {16,32,64}, all ops, compared against a 2·WIDTH-bit reference model, with random out_ready stalls.
